// File: rtl/rbi_mem_req_port_if.sv
// Bundle of the ring slot (in/out) and the client request/response handshake
// for one RBI requester node.
interface rbi_mem_req_port_if;
  logic [15:0]  memSeqIn;
  logic [15:0]  memOpmIn;
  logic [47:0]  memAddrIn;
  logic [127:0] memDataIn;
  logic [15:0]  memSeqOut;
  logic [15:0]  memOpmOut;
  logic [47:0]  memAddrOut;
  logic [127:0] memDataOut;
  logic         reqValid;
  logic         reqReady;
  logic         reqWrite;
  logic [47:0]  reqAddr;
  logic [127:0] reqData;
  logic         respValid;
  logic         respReady;
  logic [127:0] respData;
  logic         respErr;
  logic         busy;

  modport slave (
    input  memSeqIn, memOpmIn, memAddrIn, memDataIn,
    input  reqValid, reqWrite, reqAddr, reqData, respReady,
    output memSeqOut, memOpmOut, memAddrOut, memDataOut,
    output reqReady, respValid, respData, respErr, busy
  );

  modport master (
    output memSeqIn, memOpmIn, memAddrIn, memDataIn,
    output reqValid, reqWrite, reqAddr, reqData, respReady,
    input  memSeqOut, memOpmOut, memAddrOut, memDataOut,
    input  reqReady, respValid, respData, respErr, busy
  );
endinterface

// File: rtl/rbi_mem_req_port.sv
// RBI ring requester node: injects one LDX/STX per client request into an idle
// slot, strips responses addressed to this node, retries on timeout.
module rbi_mem_req_port #(
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           unitNodeId,
  rbi_mem_req_port_if.slave    bus
);

  localparam logic [7:0] JX2_RBI_OPM_IDLE = 8'h00;
  localparam logic [7:0] JX2_RBI_OPM_LDX  = 8'h93;
  localparam logic [7:0] JX2_RBI_OPM_STX  = 8'hA3;
  localparam logic [7:0] JX2_RBI_OPM_OKLD = 8'h60;
  localparam logic [7:0] JX2_RBI_OPM_OKST = 8'h70;

  localparam int unsigned TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_RESP} state_t;

  state_t       state, stateNext;
  logic [7:0]   tagCnt, issTag;
  logic [TMO_W-1:0] tmoCnt;
  logic [RTY_W-1:0] retryCnt;
  logic         writeQ;
  logic [47:0]  addrQ;
  logic [127:0] dataQ;
  logic [15:0]  seqQ, opmQ;
  logic [47:0]  ringAddrQ;
  logic [127:0] ringDataQ;
  logic [127:0] respDataQ;
  logic         respErrQ;

  logic slotIdle, forMe, tagHit, tmoHit, retryLeft, issueSlot;

  assign slotIdle  = (bus.memOpmIn[7:0] == JX2_RBI_OPM_IDLE);
  assign forMe     = (bus.memOpmIn[7:6] == 2'b01) && (bus.memSeqIn[15:8] == unitNodeId);
  assign tagHit    = forMe && (bus.memSeqIn[7:0] == issTag);
  assign tmoHit    = (32'(tmoCnt) == TIMEOUT_CYC - 1);
  assign retryLeft = (32'(retryCnt) < MAX_RETRY);
  assign issueSlot = slotIdle && !forMe;

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      ST_IDLE: if (bus.reqValid) stateNext = ST_SEND;
      ST_SEND: if (issueSlot)    stateNext = ST_WAIT;
      ST_WAIT: begin
        // A matching response takes priority over a timeout in the same cycle.
        if (tagHit)                   stateNext = ST_RESP;
        else if (tmoHit && retryLeft) stateNext = ST_SEND;
        else if (tmoHit)              stateNext = ST_RESP;
      end
      ST_RESP: if (bus.respReady) stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.reqReady   = (state == ST_IDLE);
    bus.respValid  = (state == ST_RESP);
    bus.busy       = (state != ST_IDLE);
    bus.respData   = respDataQ;
    bus.respErr    = respErrQ;
    bus.memSeqOut  = seqQ;
    bus.memOpmOut  = opmQ;
    bus.memAddrOut = ringAddrQ;
    bus.memDataOut = ringDataQ;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tagCnt    <= '0;
      issTag    <= '0;
      tmoCnt    <= '0;
      retryCnt  <= '0;
      writeQ    <= 1'b0;
      addrQ     <= '0;
      dataQ     <= '0;
      seqQ      <= '0;
      opmQ      <= {8'h00, JX2_RBI_OPM_IDLE};
      ringAddrQ <= '0;
      ringDataQ <= '0;
      respDataQ <= '0;
      respErrQ  <= 1'b0;
    end else begin
      seqQ      <= bus.memSeqIn;
      opmQ      <= bus.memOpmIn;
      ringAddrQ <= bus.memAddrIn;
      ringDataQ <= bus.memDataIn;
      // Anything addressed here is stripped, whether or not it is awaited.
      if (forMe) begin
        seqQ      <= '0;
        opmQ      <= {8'h00, JX2_RBI_OPM_IDLE};
        ringAddrQ <= '0;
        ringDataQ <= '0;
      end

      unique case (state)
        ST_IDLE: if (bus.reqValid) begin
          writeQ   <= bus.reqWrite;
          addrQ    <= bus.reqAddr & ~48'hF;
          dataQ    <= bus.reqData;
          retryCnt <= '0;
        end
        ST_SEND: if (issueSlot) begin
          seqQ      <= {unitNodeId, tagCnt};
          opmQ      <= {8'h00, writeQ ? JX2_RBI_OPM_STX : JX2_RBI_OPM_LDX};
          ringAddrQ <= addrQ;
          ringDataQ <= writeQ ? dataQ : '0;
          issTag    <= tagCnt;
          tagCnt    <= tagCnt + 8'd1;
          tmoCnt    <= '0;
        end
        ST_WAIT: begin
          tmoCnt <= tmoCnt + TMO_W'(1);
          if (tagHit) begin
            respDataQ <= bus.memDataIn;
            respErrQ  <= (bus.memOpmIn[7:0] !=
                          (writeQ ? JX2_RBI_OPM_OKST : JX2_RBI_OPM_OKLD));
          end else if (tmoHit) begin
            if (retryLeft) begin
              retryCnt <= retryCnt + RTY_W'(1);
            end else begin
              respErrQ  <= 1'b1;
              respDataQ <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rbi_mem_req_port.sv
// Directed bench for rbi_mem_req_port: table-driven ring passthrough/consume
// vectors plus hand-written load, store, wrap, busy-ring, retry and reset runs.
module tb_rbi_mem_req_port;

  localparam logic [7:0] OPM_IDLE = 8'h00;
  localparam logic [7:0] OPM_LDX  = 8'h93;
  localparam logic [7:0] OPM_STX  = 8'hA3;
  localparam logic [7:0] OPM_OKLD = 8'h60;
  localparam logic [7:0] OPM_OKST = 8'h70;

  logic clock = 1'b0;
  logic rstA, rstB;
  always #5 clock = ~clock;

  rbi_mem_req_port_if ba();
  rbi_mem_req_port_if bb();

  rbi_mem_req_port dutA (
    .clock(clock), .reset(rstA), .unitNodeId(8'h07), .bus(ba)
  );
  rbi_mem_req_port #(.TIMEOUT_CYC(8), .MAX_RETRY(1)) dutB (
    .clock(clock), .reset(rstB), .unitNodeId(8'h2A), .bus(bb)
  );

  typedef struct {
    logic [15:0]  seq;
    logic [15:0]  opm;
    logic [47:0]  addr;
    logic [127:0] data;
    logic [15:0]  eSeq;
    logic [15:0]  eOpm;
    logic [47:0]  eAddr;
    logic [127:0] eData;
  } vec_t;

  int nTests = 0;
  int nFail  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic ringA(input logic [15:0] s, input logic [15:0] o,
                       input logic [47:0] a, input logic [127:0] d);
    ba.memSeqIn = s; ba.memOpmIn = o; ba.memAddrIn = a; ba.memDataIn = d;
  endtask

  task automatic ringB(input logic [15:0] s, input logic [15:0] o,
                       input logic [47:0] a, input logic [127:0] d);
    bb.memSeqIn = s; bb.memOpmIn = o; bb.memAddrIn = a; bb.memDataIn = d;
  endtask

  task automatic waitIssueA(output int cyc, output logic [15:0] seq);
    cyc = 0;
    while (!((ba.memOpmOut[7:0] == OPM_LDX || ba.memOpmOut[7:0] == OPM_STX) &&
             ba.memSeqOut[15:8] == 8'h07) && cyc < 50) begin
      step();
      cyc++;
    end
    seq = ba.memSeqOut;
  endtask

  task automatic waitIssueB(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (bb.memOpmOut[7:0] != OPM_LDX && cyc < 30);
  endtask

  // One complete request on node A, answered by the bench with code ok.
  task automatic txnA(input logic w, input logic [47:0] a, input logic [127:0] d,
                      input logic [7:0] ok, input logic [127:0] rd,
                      output logic [15:0] seq, output int cyc, output logic rv,
                      output logic err, output logic [127:0] got);
    ba.reqValid = 1'b1; ba.reqWrite = w; ba.reqAddr = a; ba.reqData = d;
    step();
    ba.reqValid = 1'b0;
    waitIssueA(cyc, seq);
    ringA(seq, {8'h00, ok}, 48'h0, rd);
    step();
    ringA(16'h0, {8'h00, OPM_IDLE}, 48'h0, 128'h0);
    rv = ba.respValid; err = ba.respErr; got = ba.respData;
    ba.respReady = 1'b1;
    step();
    ba.respReady = 1'b0;
  endtask

  vec_t vecs[7];
  logic [15:0]  seq;
  int           cyc;
  logic         rv, err;
  logic [127:0] got;
  int           bad;

  initial begin
    vecs[0] = '{16'h0512, 16'h0093, 48'h0000_0000_8000, 128'h0,
                16'h0512, 16'h0093, 48'h0000_0000_8000, 128'h0};
    vecs[1] = '{16'h0300, 16'h0060, 48'h0000_0000_0000, 128'h55,
                16'h0300, 16'h0060, 48'h0000_0000_0000, 128'h55};
    vecs[2] = '{16'h0742, 16'h0060, 48'h0000_0000_0010, 128'hABC,
                16'h0000, 16'h0000, 48'h0000_0000_0000, 128'h0};
    vecs[3] = '{16'h0701, 16'h0093, 48'h0000_1234_5670, 128'h1,
                16'h0701, 16'h0093, 48'h0000_1234_5670, 128'h1};
    vecs[4] = '{16'h07FF, 16'h0070, 48'h0000_0000_0020, 128'h2,
                16'h0000, 16'h0000, 48'h0000_0000_0000, 128'h0};
    vecs[5] = '{16'h0000, 16'h0000, 48'h0000_0000_0000, 128'h0,
                16'h0000, 16'h0000, 48'h0000_0000_0000, 128'h0};
    vecs[6] = '{16'h0811, 16'h0140, 48'hFFFF_FFFF_FFF0, 128'hF00D,
                16'h0811, 16'h0140, 48'hFFFF_FFFF_FFF0, 128'hF00D};

    rstA = 1'b0; rstB = 1'b0;
    ba.reqValid = 1'b0; ba.reqWrite = 1'b0; ba.reqAddr = '0; ba.reqData = '0; ba.respReady = 1'b0;
    bb.reqValid = 1'b0; bb.reqWrite = 1'b0; bb.reqAddr = '0; bb.reqData = '0; bb.respReady = 1'b0;
    ringA(16'h0123, 16'h0093, 48'h40, 128'h9);
    ringB(16'h0123, 16'h0093, 48'h40, 128'h9);
    step(); step();

    chk("rst seqOut",   ba.memSeqOut, 16'h0);
    chk("rst opmOut",   ba.memOpmOut, 16'h0);
    chk("rst addrOut",  ba.memAddrOut, 48'h0);
    chk("rst dataOut",  ba.memDataOut, 128'h0);
    chk("rst respValid", ba.respValid, 1'b0);
    chk("rst busy",     ba.busy, 1'b0);
    chk("rst respData", ba.respData, 128'h0);
    chk("rst reqReady", ba.reqReady, 1'b1);
    chk("rstB seqOut",  bb.memSeqOut, 16'h0);

    rstA = 1'b1; rstB = 1'b1;
    ringA(16'h0, {8'h00, OPM_IDLE}, 48'h0, 128'h0);
    ringB(16'h0, {8'h00, OPM_IDLE}, 48'h0, 128'h0);
    step();

    // Passthrough and consume table, node A idle.
    for (int unsigned i = 0; i < 7; i++) begin
      ringA(vecs[i].seq, vecs[i].opm, vecs[i].addr, vecs[i].data);
      step();
      chk($sformatf("vec%0d seq", i),  ba.memSeqOut,  vecs[i].eSeq);
      chk($sformatf("vec%0d opm", i),  ba.memOpmOut,  vecs[i].eOpm);
      chk($sformatf("vec%0d addr", i), ba.memAddrOut, vecs[i].eAddr);
      chk($sformatf("vec%0d data", i), ba.memDataOut, vecs[i].eData);
    end
    chk("vec respValid", ba.respValid, 1'b0);
    ringA(16'h0, {8'h00, OPM_IDLE}, 48'h0, 128'h0);
    step();

    // Load, tag 0.
    ba.reqValid = 1'b1; ba.reqWrite = 1'b0; ba.reqAddr = 48'h0000_0000_0123;
    ba.reqData = 128'h5A5A;
    step();
    ba.reqValid = 1'b0;
    chk("ld busy", ba.busy, 1'b1);
    chk("ld reqReady", ba.reqReady, 1'b0);
    step();
    chk("ld seq",  ba.memSeqOut, 16'h0700);
    chk("ld opm",  ba.memOpmOut, {8'h00, OPM_LDX});
    chk("ld addr", ba.memAddrOut, 48'h0000_0000_0120);
    chk("ld data", ba.memDataOut, 128'h0);
    repeat (4) step();
    ringA(16'h0700, {8'h00, OPM_OKLD}, 48'h0, 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0001);
    step();
    ringA(16'h0, {8'h00, OPM_IDLE}, 48'h0, 128'h0);
    chk("ld respValid", ba.respValid, 1'b1);
    chk("ld respData", ba.respData, 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0001);
    chk("ld respErr", ba.respErr, 1'b0);
    chk("ld consumed seq", ba.memSeqOut, 16'h0);
    chk("ld consumed opm", ba.memOpmOut, 16'h0);
    step();
    chk("ld respValid held", ba.respValid, 1'b1);
    ba.respReady = 1'b1;
    step();
    ba.respReady = 1'b0;
    chk("ld back idle", ba.respValid, 1'b0);
    chk("ld reqReady", ba.reqReady, 1'b1);

    // Walk the tag up to 8'hFE.
    bad = 0;
    for (int i = 1; i < 255; i++) begin
      txnA(1'b0, 48'(i * 16), 128'h0, OPM_OKLD, 128'(i), seq, cyc, rv, err, got);
      if (seq !== {8'h07, 8'(i)} || cyc != 1 || rv !== 1'b1 || err !== 1'b0 || got !== 128'(i))
        bad++;
    end
    chk("tag walk errors", bad, 0);

    // Store with tag FF.
    ba.reqValid = 1'b1; ba.reqWrite = 1'b1; ba.reqAddr = 48'h0000_0000_C000;
    ba.reqData = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    step();
    ba.reqValid = 1'b0;
    step();
    chk("st seq",  ba.memSeqOut, 16'h07FF);
    chk("st opm",  ba.memOpmOut, {8'h00, OPM_STX});
    chk("st addr", ba.memAddrOut, 48'h0000_0000_C000);
    chk("st data", ba.memDataOut, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321);
    step(); step();
    ringA(16'h07FF, {8'h00, OPM_OKST}, 48'h0, 128'h0);
    step();
    ringA(16'h0, {8'h00, OPM_IDLE}, 48'h0, 128'h0);
    chk("st respValid", ba.respValid, 1'b1);
    chk("st respErr", ba.respErr, 1'b0);
    chk("st consumed", ba.memSeqOut, 16'h0);
    ba.respReady = 1'b1;
    step();
    ba.respReady = 1'b0;

    // Tag wrapped to 0; answer a load with the store code.
    txnA(1'b0, 48'h10, 128'h0, OPM_OKST, 128'h7, seq, cyc, rv, err, got);
    chk("wrap seq", seq, 16'h0700);
    chk("bad code respValid", rv, 1'b1);
    chk("bad code respErr", err, 1'b1);

    // Busy ring: 20 foreign slots, then one idle slot.
    ba.reqValid = 1'b1; ba.reqWrite = 1'b0; ba.reqAddr = 48'h0000_0000_0AB7;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      ringA(16'h0200 + 16'(i), 16'h0093, 48'(i), 128'(i + 100));
      step();
      if (ba.memSeqOut !== 16'h0200 + 16'(i) || ba.memOpmOut !== 16'h0093 ||
          ba.memAddrOut !== 48'(i) || ba.memDataOut !== 128'(i + 100))
        bad++;
    end
    ba.reqValid = 1'b0;
    chk("busy ring forward errors", bad, 0);
    chk("busy ring still busy", ba.busy, 1'b1);
    ringA(16'h0, {8'h00, OPM_IDLE}, 48'h0, 128'h0);
    step();
    chk("busy ring inject seq", ba.memSeqOut, 16'h0701);
    chk("busy ring inject addr", ba.memAddrOut, 48'h0000_0000_0AB0);
    ringA(16'h0701, {8'h00, OPM_OKLD}, 48'h0, 128'h31);
    step();
    ringA(16'h0, {8'h00, OPM_IDLE}, 48'h0, 128'h0);
    chk("busy ring resp", ba.respData, 128'h31);
    ba.respReady = 1'b1;
    step();
    ba.respReady = 1'b0;

    // Node B: timeout 8, one retry.
    bb.reqValid = 1'b1; bb.reqWrite = 1'b0; bb.reqAddr = 48'h40;
    step();
    bb.reqValid = 1'b0;
    step();
    chk("tmo first seq", bb.memSeqOut, 16'h2A00);
    waitIssueB(cyc);
    chk("tmo reissue gap", cyc, 9);
    chk("tmo reissue seq", bb.memSeqOut, 16'h2A01);
    cyc = 0;
    while (bb.respValid !== 1'b1 && cyc < 30) begin
      step();
      cyc++;
    end
    chk("tmo final gap", cyc, 8);
    chk("tmo respErr", bb.respErr, 1'b1);
    chk("tmo respData", bb.respData, 128'h0);
    bb.respReady = 1'b1;
    step();
    bb.respReady = 1'b0;

    // Stale response after a retry.
    bb.reqValid = 1'b1;
    step();
    bb.reqValid = 1'b0;
    step();
    chk("stale first seq", bb.memSeqOut, 16'h2A02);
    waitIssueB(cyc);
    chk("stale reissue seq", bb.memSeqOut, 16'h2A03);
    ringB(16'h2A02, {8'h00, OPM_OKLD}, 48'h0, 128'h77);
    step();
    chk("stale consumed", bb.memOpmOut, 16'h0);
    chk("stale no respValid", bb.respValid, 1'b0);
    ringB(16'h2A03, {8'h00, OPM_OKLD}, 48'h0, 128'h88);
    step();
    ringB(16'h0, {8'h00, OPM_IDLE}, 48'h0, 128'h0);
    chk("current respValid", bb.respValid, 1'b1);
    chk("current respErr", bb.respErr, 1'b0);
    chk("current respData", bb.respData, 128'h88);
    bb.respReady = 1'b1;
    step();
    bb.respReady = 1'b0;

    // Response lands on the timeout cycle.
    bb.reqValid = 1'b1;
    step();
    bb.reqValid = 1'b0;
    step();
    chk("race seq", bb.memSeqOut, 16'h2A04);
    repeat (7) step();
    ringB(16'h2A04, {8'h00, OPM_OKLD}, 48'h0, 128'h99);
    step();
    ringB(16'h0, {8'h00, OPM_IDLE}, 48'h0, 128'h0);
    chk("race respValid", bb.respValid, 1'b1);
    chk("race respErr", bb.respErr, 1'b0);
    chk("race respData", bb.respData, 128'h99);
    chk("race no reissue", bb.memOpmOut, 16'h0);
    bb.respReady = 1'b1;
    step();
    bb.respReady = 1'b0;

    // Reset while waiting; the late response is stripped afterwards.
    bb.reqValid = 1'b1;
    step();
    bb.reqValid = 1'b0;
    step();
    chk("rst-wait seq", bb.memSeqOut, 16'h2A05);
    step(); step();
    ringB(16'h0111, 16'h0093, 48'h50, 128'h3);
    rstB = 1'b0;
    step();
    chk("rst-wait seqOut",  bb.memSeqOut, 16'h0);
    chk("rst-wait opmOut",  bb.memOpmOut, 16'h0);
    chk("rst-wait addrOut", bb.memAddrOut, 48'h0);
    chk("rst-wait dataOut", bb.memDataOut, 128'h0);
    chk("rst-wait busy",    bb.busy, 1'b0);
    chk("rst-wait respValid", bb.respValid, 1'b0);
    rstB = 1'b1;
    ringB(16'h2A05, {8'h00, OPM_OKLD}, 48'h0, 128'h5);
    step();
    ringB(16'h0, {8'h00, OPM_IDLE}, 48'h0, 128'h0);
    chk("late consumed seq", bb.memSeqOut, 16'h0);
    chk("late consumed data", bb.memDataOut, 128'h0);
    chk("late no respValid", bb.respValid, 1'b0);
    chk("late not busy", bb.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/rbi_mem_req_port.md
Name: rbi_mem_req_port

Overview:
- Ring-bus initiator node: the requester end of the RBI load/store protocol.
- Accepts single load/store requests from a local client and injects each as an LDX/STX message into an idle ring slot.
- Removes the matching OKLD/OKST response addressed to its `unitNodeId` and returns it to the client.
- Sits on the ring beside responders such as the L2 ROM/SRAM tile; forwards all foreign traffic with one registered stage.

Parameters:
- TIMEOUT_CYC, 1023: cycles to wait in WAIT before re-issuing the request.
- MAX_RETRY, 3: re-issues allowed before the request completes with an error.

Ports:
- clock  in  1  : single clock domain.
- reset  in  1  : synchronous, active-low (0 = reset).
- memSeqIn  in  16  : ring sequence in; [15:8] = node ID, [7:0] = tag.
- memOpmIn  in  16  : ring operation mode in.
- memAddrIn  in  48  : ring address in.
- memDataIn  in  128  : ring data in.
- memSeqOut  out  16  : ring sequence out.
- memOpmOut  out  16  : ring operation mode out.
- memAddrOut  out  48  : ring address out.
- memDataOut  out  128  : ring data out.
- unitNodeId  in  8  : this node's ID.
- reqValid  in  1  : client request valid.
- reqReady  out  1  : request accepted when both reqValid and reqReady are high.
- reqWrite  in  1  : 1 = STX, 0 = LDX.
- reqAddr  in  48  : request address; bits [3:0] are ignored and sent as 0.
- reqData  in  128  : store data.
- respValid  out  1  : response available; held until respReady.
- respReady  in  1  : client takes the response.
- respData  out  128  : load data; unspecified for stores.
- respErr  out  1  : valid with respValid; wrong OK code or retries exhausted.
- busy  out  1  : a request is in flight (state not IDLE).

Behaviour:
- All four ring outputs are registered. Latency from ring in to ring out is exactly 1 cycle.
- Default each cycle: the ring output copies the ring input.
- Decode of the incoming slot:
  - idle = (memOpmIn[7:0] == JX2_RBI_OPM_IDLE)
  - forMe = (memOpmIn[7:6] == 2'b01) && (memSeqIn[15:8] == unitNodeId)
- Consume rule: whenever forMe is true, in any state, the slot is replaced by an idle slot.
  - Idle slot = seq 0, opm JX2_RBI_OPM_IDLE, addr 0, data 0.
  - A response is never forwarded past its requester.
- Tag counter:
  - 8-bit; reset value 0.
  - Incremented on each issue, including retries; wraps from 255 to 0.
- State machine:
  - IDLE:
    - reqReady = 1.
    - On handshake, latch write/addr/data, clear the retry count, go to SEND.
  - SEND:
    - Waits for an input slot that is idle and not forMe.
    - In that slot, drive seq = {unitNodeId, tag}, opm = {8'h00, LDX or STX}, addr = {reqAddr[47:4], 4'h0}, data = reqData for STX or 0 for LDX.
    - Record the issued tag, clear the timeout counter, go to WAIT.
    - If the ring never presents an idle slot, stay in SEND indefinitely; no timeout applies in SEND.
  - WAIT:
    - The timeout counter increments each cycle.
    - If forMe and seq[7:0] equals the issued tag:
      - Capture memDataIn into respData.
      - respErr = 0 if opm[7:0] is OKLD for a load or OKST for a store; otherwise respErr = 1.
      - Go to RESP.
    - A forMe slot with a mismatched tag is consumed and dropped; the state is unchanged.
    - If the counter reaches TIMEOUT_CYC:
      - If retries < MAX_RETRY: increment retries, go to SEND (new tag).
      - Otherwise: respErr = 1, respData = 0, go to RESP.
    - A matching response and a timeout in the same cycle: the response wins.
  - RESP:
    - respValid = 1.
    - When respReady, go to IDLE; reqReady rises in the next cycle.
    - No new request is accepted in RESP.
    - Late or duplicate responses in RESP or IDLE are consumed and dropped.
- Reset (reset == 0):
  - State = IDLE; tag, retry count and timeout counter = 0.
  - respValid, respErr, busy = 0; respData = 0.
  - memSeqOut = 0, memOpmOut = JX2_RBI_OPM_IDLE, memAddrOut = 0, memDataOut = 0.
  - A request in flight is abandoned. Its eventual response still matches unitNodeId, so the consume rule removes it.

Test Plan:
1. Passthrough: reqValid = 0; drive seq 16'h0512, opm LDX, addr 48'h0000_0000_8000, data 0 with unitNodeId = 8'h07 → the same values appear on the outputs exactly 1 cycle later.
2. Load:
   - Request LDX at 48'h0000_0000_0123 → outputs show seq 16'h0700, addr 48'h0000_0000_0120.
   - Bench returns OKLD, seq 16'h0700, data 128'hDEAD_BEEF_...0001 after 5 cycles → respValid = 1, respData matches, respErr = 0.
   - The response slot leaves as idle.
3. Store then tag wrap:
   - Preload tag = 8'hFF, STX at 48'h0000_0000_C000 with data 128'h1234...; bench answers OKST on seq 16'h07FF → respErr = 0.
   - The next request is issued with seq 16'h0700.
4. Busy ring: input slots stay non-idle for 20 cycles while reqValid = 1 → no injection and all traffic forwarded; injection occurs in the first idle slot.
5. Timeout/retry: TIMEOUT_CYC = 8, MAX_RETRY = 1, no response → re-issue with tag+1 after 8 cycles in WAIT; after a second timeout → respValid = 1, respErr = 1.
6. Stale response and reset:
   - A response with the old tag arriving after a retry is consumed without respValid; the current tag still completes.
   - reset = 0 asserted in WAIT → all outputs at their reset values on the next edge; the late response is later consumed.
